// File: rtl/regfile_scoreboard.sv
// Parametrised register file with a per-register pending (scoreboard) bit.
// Decode reads and reserves destinations; write-back writes and releases them.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          write_register,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       reserve_en,
  input  logic [ADDR_W-1:0]          reserve_register,
  input  logic [NUM_RD*ADDR_W-1:0]   read_register,
  output logic [NUM_RD*DATA_W-1:0]   read_data,
  output logic [NUM_RD-1:0]          read_pending,
  output logic                       any_pending
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic wr_en_c;
  logic rsv_en_c;

  // Register 0 swallows writes and reserves when hardwired.
  always_comb begin
    wr_en_c  = reg_write;
    rsv_en_c = reserve_en;
    if (ZERO_REG) begin
      if (write_register == '0) wr_en_c = 1'b0;
      if (reserve_register == '0) rsv_en_c = 1'b0;
    end
  end

  // Next state: reserve is applied after write so that set wins on a collision.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_en_c) begin
      mem_d[write_register]  = write_data;
      pend_d[write_register] = 1'b0;
    end
    if (rsv_en_c) begin
      pend_d[reserve_register] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pend;
    read_data    = '0;
    read_pending = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      addr = read_register[k*ADDR_W +: ADDR_W];
      data = mem_q[addr];
      pend = pend_q[addr];
      if (BYPASS && wr_en_c && (addr == write_register)) begin
        data = write_data;
        pend = rsv_en_c && (reserve_register == addr);
      end
      if (ZERO_REG && (addr == '0)) begin
        data = '0;
        pend = 1'b0;
      end
      read_data[k*DATA_W +: DATA_W] = data;
      read_pending[k]               = pend;
    end
  end

  assign any_pending = |pend_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8x16 register file.
- Adds configurable width, depth and read-port count; async active-low reset of the whole array; optional register-0 hardwiring; optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit, so the pipeline can detect read-after-write hazards on destinations that have issued but not yet been written back.
- Sits between decode (reads, reserve) and write-back (write) in the MIPS datapath.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- BYPASS, 0, 1 = same-cycle write data forwarded to reads; 0 = write visible next cycle
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never pending

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reg_write  in  1  write enable, sampled on rising clk
- write_register  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- reserve_en  in  1  mark a destination pending, sampled on rising clk
- reserve_register  in  ADDR_W  destination to mark pending
- read_register  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  packed read data, combinational
- read_pending  out  NUM_RD  1 = addressed register awaits write-back
- any_pending  out  1  OR of all pending bits

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low immediately clears all registers to 0 and all pending bits to 0, independent of clk.
  - Outputs therefore read 0 and read_pending/any_pending read 0 while reset is held.
  - Deassertion is sampled on the next rising edge; a write presented in that same cycle is accepted.
- Write: on rising clk with reg_write=1, mem[write_register] <= write_data.
- Read: read_data[k] = mem[read_register[k]], purely combinational; no read latency.
- BYPASS=0: a read of the register written this cycle returns the old value; the new value appears after the edge. This matches the existing register file.
- BYPASS=1: if reg_write=1 and read_register[k]==write_register, read_data[k]=write_data in the same cycle, and read_pending[k] is forced to 0 unless reserve_en targets the same register in that cycle.
- Scoreboard:
  - pending[i] is set on a rising edge with reserve_en=1 and reserve_register=i.
  - pending[i] is cleared on a rising edge with reg_write=1 and write_register=i.
  - Simultaneous reserve and write to the same register: set wins. The new producer is in flight; the data is still written.
  - Simultaneous reserve and write to different registers: both take effect.
  - Re-reserving an already pending register keeps it pending; there is no count. A single write clears it.
  - A write to a non-pending register is legal and leaves pending at 0.
- ZERO_REG=1:
  - Address 0 always reads 0 with read_pending 0.
  - Writes and reserves to address 0 are dropped; bypass never forwards to address 0.
- Multiple read ports may address the same register; each returns the identical value.
- Reset asserted mid-operation: array and scoreboard clear immediately; in-flight reserves are lost.
- No X propagation: every output is defined for all address values.

Test Plan:
1. Reset, BYPASS=0: write r4=20 with read_register[0]=4. Port 0 shows 0 in the write cycle and 20 after the edge; an r0 read returns 0.
2. BYPASS=1, same stimulus: port 0 shows 20 in the write cycle, before the edge.
3. Scoreboard: reserve r5, then on the next cycle read r5 → read_pending=1 and any_pending=1. Write r5=0x1234 → pending=0 after the edge, data=0x1234.
4. Collision: reserve r3 and write r3=7 in the same cycle → after the edge r3=7 and pending[3]=1. A later write r3=9 clears it.
5. ZERO_REG=1: write r0=0xFFFF and reserve r0 → reads of r0 return 0 with pending 0. NUM_RD=3, all ports reading r6=0xABCD → all three return 0xABCD.
6. Async reset: write r2=0x55 and reserve r7, then pulse rst_n low between clock edges → read_data and read_pending go to 0 immediately, without waiting for clk.
